// File: rtl/seq_mem_pkg.sv
// Shared types and default sizing for the seq_mem read-side stream stages.
package seq_mem_pkg;

    // Burst reader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default geometry, matching the seq_mem_d1 instance this block feeds from.
    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_SIZE       = 64;
    localparam int DEFAULT_IDX_SIZE   = 8;
    localparam int DEFAULT_LEN_WIDTH  = 9;
    localparam int DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/seq_mem_rd_fifo.sv
// Small synchronous FIFO with a registered head entry and an occupancy count.
// The producer is expected to track credit against count, so a push into a
// full FIFO (without a simultaneous pop) is treated as a design error.
module seq_mem_rd_fifo
    import seq_mem_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH + 1,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic do_pop;
    logic do_push;

    assign full       = (count_q == FULL_CNT);
    assign do_pop     = pop && (count_q != '0);
    assign do_push    = push && (!full || do_pop);
    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

    // Pointer, count and storage updates for the coming cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset flushes the FIFO regardless of contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // A push into a full FIFO means the upstream credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/seq_mem_burst_reader.sv
// Burst read sequencer in front of a seq_mem_d1 memory. A command (base
// address, length) becomes one read per cycle while credit allows; each
// registered memory response lands in a small FIFO that feeds a valid/ready
// output stream, so downstream backpressure can never drop a response.
module seq_mem_burst_reader
    import seq_mem_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int IDX_SIZE   = DEFAULT_IDX_SIZE,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IDX_SIZE-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    output logic                 cmd_err,
    output logic                 burst_done,

    output logic [IDX_SIZE-1:0]  mem_addr0,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    input  logic [WIDTH-1:0]     mem_out,
    input  logic                 mem_read_done,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_SIZE:0]    SIZE_LIMIT = (IDX_SIZE + 1)'(SIZE);
    localparam logic [IDX_SIZE-1:0]  LAST_ADDR  = IDX_SIZE'(SIZE - 1);
    localparam logic [CNT_W:0]       CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE_LEFT   = LEN_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [IDX_SIZE-1:0]    addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic                   last_pending_q, last_pending_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   burst_done_q, burst_done_d;
    logic                   ignore_done_q;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_valid;
    logic [WIDTH:0]         fifo_head;
    logic [CNT_W:0]         occupancy;
    logic                   credit;
    logic                   issue;
    logic                   capture;
    logic                   pop;

    // A read may go out only if the slot it will need is already reserved:
    // entries held, plus the response still in flight, minus the beat
    // leaving this cycle, must leave room for one more.
    always_comb begin
        pop       = fifo_valid && out_ready;
        occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        credit    = (occupancy < CREDIT_MAX);
        issue     = (state_q == ISSUE) && credit;
        capture   = mem_read_done && !ignore_done_q;
    end

    assign mem_read_en  = issue;
    assign mem_addr0    = addr_q;
    assign mem_write_en = 1'b0;
    assign cmd_ready    = (state_q == IDLE);
    assign cmd_err      = cmd_err_q;
    assign burst_done   = burst_done_q;
    assign out_valid    = fifo_valid;
    assign out_data     = fifo_head[WIDTH-1:0];
    assign out_last     = fifo_head[WIDTH] && fifo_valid;

    // Next-state logic for command handling, issue sequencing and drain.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        inflight_d     = inflight_q;
        last_pending_d = last_pending_q;
        cmd_err_d      = 1'b0;
        burst_done_d   = 1'b0;

        if (capture) begin
            inflight_d     = 1'b0;
            last_pending_d = 1'b0;
        end

        if (issue) begin
            inflight_d     = 1'b1;
            last_pending_d = (remaining_q == ONE_LEFT);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if ({1'b0, cmd_addr} >= SIZE_LIMIT) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        burst_done_d = 1'b1;
                    end else begin
                        addr_d      = cmd_addr;
                        remaining_d = cmd_len;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + IDX_SIZE'(1);
                    remaining_d = remaining_q - ONE_LEFT;
                    if (remaining_q == ONE_LEFT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_head[WIDTH]) begin
                    state_d      = IDLE;
                    burst_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; the response arriving just after a reset belongs
    // to an abandoned burst, so it is masked for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            inflight_q     <= 1'b0;
            last_pending_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            burst_done_q   <= 1'b0;
            ignore_done_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            inflight_q     <= inflight_d;
            last_pending_q <= last_pending_d;
            cmd_err_q      <= cmd_err_d;
            burst_done_q   <= burst_done_d;
            ignore_done_q  <= 1'b0;
        end
    end

    seq_mem_rd_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (capture),
        .push_data  ({last_pending_q, mem_out}),
        .pop        (pop),
        .head_data  (fifo_head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_seq_mem_burst_reader.sv
// Directed bench for seq_mem_burst_reader with a behavioural seq_mem_d1
// (one-cycle registered read) preloaded with mem[i] = i*0x11.
module tb_seq_mem_burst_reader;

    localparam int WIDTH     = 32;
    localparam int SIZE      = 64;
    localparam int IDX_SIZE  = 8;
    localparam int LEN_WIDTH = 9;
    localparam int DEPTH     = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmdValid;
    logic                 cmdReady;
    logic [IDX_SIZE-1:0]  cmdAddr;
    logic [LEN_WIDTH-1:0] cmdLen;
    logic                 cmdErr;
    logic                 burstDone;
    logic [IDX_SIZE-1:0]  memAddr0;
    logic                 memReadEn;
    logic                 memWriteEn;
    logic [WIDTH-1:0]     memOut;
    logic                 memReadDone;
    logic                 outValid;
    logic                 outReady;
    logic [WIDTH-1:0]     outData;
    logic                 outLast;

    logic [WIDTH-1:0]     memArray [SIZE];

    int checks = 0;
    int errors = 0;

    seq_mem_burst_reader dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmdValid),
        .cmd_ready     (cmdReady),
        .cmd_addr      (cmdAddr),
        .cmd_len       (cmdLen),
        .cmd_err       (cmdErr),
        .burst_done    (burstDone),
        .mem_addr0     (memAddr0),
        .mem_read_en   (memReadEn),
        .mem_write_en  (memWriteEn),
        .mem_out       (memOut),
        .mem_read_done (memReadDone),
        .out_valid     (outValid),
        .out_ready     (outReady),
        .out_data      (outData),
        .out_last      (outLast)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory model: registered read, read_done one cycle after read_en.
    always @(posedge clk) begin
        memReadDone <= memReadEn;
        if (memReadEn) begin
            memOut <= memArray[memAddr0[5:0]];
        end
    end

    // Absolute guard so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int addr, input int len);
        cmdValid = 1'b1;
        cmdAddr  = IDX_SIZE'(addr);
        cmdLen   = LEN_WIDTH'(len);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one burst from IDLE: mode 0 ready always, 1 ready pattern 1,0,0,
    // 2 random ready. Entered and left one time unit after a rising edge.
    task automatic runBurst(input int addr, input int len, input int mode,
                            output int firstBeatCycle, output int lastBeatCycle,
                            output int doneCycle);
        int issued = 0;
        int popped = 0;
        int lastCount = 0;
        int cyc = 1;
        int bound;
        bit finished = 0;
        bit prevStalled = 0;
        logic [WIDTH-1:0] prevData = '0;
        firstBeatCycle = -1;
        lastBeatCycle = -1;
        doneCycle = -1;
        bound = 20 * len + 50;

        applyStimulus(addr, len);
        #1;
        checkOutput("cmd_ready_at_accept", 64'(cmdReady), 64'd1);
        tick;
        cmdValid = 1'b0;

        while (!finished && cyc < bound) begin
            case (mode)
                0:       outReady = 1'b1;
                1:       outReady = ((cyc - 1) % 3 == 0);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (memReadEn) begin
                checkOutput("mem_addr0", 64'(memAddr0), 64'((addr + issued) % SIZE));
                issued++;
            end
            if (prevStalled) begin
                checkOutput("stall_valid", 64'(outValid), 64'd1);
                checkOutput("stall_data", 64'(outData), 64'(prevData));
            end
            if (outValid && outReady) begin
                if (popped == 0) firstBeatCycle = cyc;
                checkOutput("beat_data", 64'(outData), 64'(memArray[(addr + popped) % SIZE]));
                checkOutput("beat_last", 64'(outLast), 64'(popped == len - 1));
                if (outLast) lastCount++;
                lastBeatCycle = cyc;
                popped++;
                prevStalled = 1'b0;
            end else begin
                prevStalled = outValid;
                prevData = outData;
            end
            checkOutput("credit_bound", 64'((issued - popped) <= DEPTH), 64'd1);
            if (burstDone) begin
                doneCycle = cyc;
                checkOutput("cmd_ready_at_done", 64'(cmdReady), 64'd1);
                finished = 1'b1;
            end
            tick;
            cyc++;
        end

        if (!finished) checkOutput("burst_timeout", 64'd0, 64'd1);
        checkOutput("beat_count", 64'(popped), 64'(len));
        checkOutput("issue_count", 64'(issued), 64'(len));
        checkOutput("last_count", 64'(lastCount), 64'd1);
        checkOutput("done_after_last", 64'(doneCycle), 64'(lastBeatCycle + 1));
        checkOutput("done_single_pulse", 64'(burstDone), 64'd0);
        outReady = 1'b0;
    endtask

    initial begin
        int firstBeat;
        int lastBeat;
        int doneAt;
        int cyc;
        int seen;

        for (int i = 0; i < SIZE; i++) begin
            memArray[i] = WIDTH'(i * 32'h11);
        end
        reset    = 1'b1;
        cmdValid = 1'b0;
        cmdAddr  = '0;
        cmdLen   = '0;
        outReady = 1'b0;

        // Reset state.
        tick;
        tick;
        checkOutput("rst_cmd_ready", 64'(cmdReady), 64'd1);
        checkOutput("rst_cmd_err", 64'(cmdErr), 64'd0);
        checkOutput("rst_burst_done", 64'(burstDone), 64'd0);
        checkOutput("rst_read_en", 64'(memReadEn), 64'd0);
        checkOutput("rst_addr0", 64'(memAddr0), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_out_last", 64'(outLast), 64'd0);
        checkOutput("rst_write_en", 64'(memWriteEn), 64'd0);
        reset = 1'b0;
        tick;

        // Basic burst, full throughput: beats on cycles 3,4,5, done on 6.
        $display("[TB] burst addr=4 len=3 ready=1");
        runBurst(4, 3, 0, firstBeat, lastBeat, doneAt);
        checkOutput("b1_first_cycle", 64'(firstBeat), 64'd3);
        checkOutput("b1_last_cycle", 64'(lastBeat), 64'd5);
        checkOutput("b1_done_cycle", 64'(doneAt), 64'd6);
        tick;

        // Same burst under backpressure.
        $display("[TB] burst addr=4 len=3 ready toggling");
        runBurst(4, 3, 1, firstBeat, lastBeat, doneAt);
        tick;

        // Address wrap at the top of memory.
        $display("[TB] burst addr=62 len=4 wrap");
        runBurst(62, 4, 0, firstBeat, lastBeat, doneAt);
        checkOutput("wrap_first_cycle", 64'(firstBeat), 64'd3);
        tick;

        // Out-of-range command is rejected with a single cmd_err pulse.
        $display("[TB] bad address command");
        applyStimulus(64, 5);
        tick;
        cmdValid = 1'b0;
        checkOutput("err_pulse", 64'(cmdErr), 64'd1);
        checkOutput("err_no_read", 64'(memReadEn), 64'd0);
        checkOutput("err_ready", 64'(cmdReady), 64'd1);
        checkOutput("err_no_done", 64'(burstDone), 64'd0);
        tick;
        checkOutput("err_pulse_end", 64'(cmdErr), 64'd0);
        checkOutput("err_no_read2", 64'(memReadEn), 64'd0);
        tick;
        checkOutput("err_no_read3", 64'(memReadEn), 64'd0);
        checkOutput("err_no_valid", 64'(outValid), 64'd0);

        // Zero-length command completes immediately.
        $display("[TB] zero-length command");
        applyStimulus(4, 0);
        tick;
        cmdValid = 1'b0;
        checkOutput("len0_done", 64'(burstDone), 64'd1);
        checkOutput("len0_no_err", 64'(cmdErr), 64'd0);
        checkOutput("len0_no_read", 64'(memReadEn), 64'd0);
        checkOutput("len0_ready", 64'(cmdReady), 64'd1);
        tick;
        checkOutput("len0_done_end", 64'(burstDone), 64'd0);
        checkOutput("len0_no_read2", 64'(memReadEn), 64'd0);
        checkOutput("len0_no_valid", 64'(outValid), 64'd0);

        // Reset in the middle of a burst, after two beats have left.
        $display("[TB] reset mid-burst");
        applyStimulus(10, 5);
        tick;
        cmdValid = 1'b0;
        outReady = 1'b1;
        cyc = 1;
        seen = 0;
        while (seen < 2 && cyc < 20) begin
            if (outValid) seen++;
            tick;
            cyc++;
        end
        checkOutput("mid_beats_seen", 64'(seen), 64'd2);
        checkOutput("mid_reset_cycle", 64'(cyc), 64'd5);
        reset = 1'b1;
        checkOutput("mid_issue_before_reset", 64'(memReadEn), 64'd1);
        tick;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
        checkOutput("mid_rst_ready", 64'(cmdReady), 64'd1);
        checkOutput("mid_rst_read", 64'(memReadEn), 64'd0);
        checkOutput("mid_rst_done", 64'(burstDone), 64'd0);
        tick;
        checkOutput("mid_stale_ignored", 64'(outValid), 64'd0);
        checkOutput("mid_stale_last", 64'(outLast), 64'd0);
        outReady = 1'b0;
        tick;
        runBurst(0, 1, 0, firstBeat, lastBeat, doneAt);
        checkOutput("post_rst_first_cycle", 64'(firstBeat), 64'd3);
        checkOutput("post_rst_done_cycle", 64'(doneAt), 64'd4);
        tick;

        // Long burst wrapping the memory four times with random backpressure.
        $display("[TB] burst addr=0 len=256 random ready");
        runBurst(0, 256, 2, firstBeat, lastBeat, doneAt);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
